// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-port synchronous data memory between the CPU
//   execute/memory stage and a host/debug port. The CPU normally wins
//   when both request. A saturating wait counter lets a starved host win
//   one cycle. A halt mode (RUN -> DRAIN -> HALTED) gives the host
//   exclusive use of the memory while the CPU is frozen.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   cpu_req/we/addr/wdata    CPU access request, store flag, address, store data
//   cpu_stall         CPU request not serviced this cycle
//   cpu_rdata/rvalid  CPU load data, valid for one cycle
//   host_req/we/addr/wdata   host access request, write flag, address, write data
//   host_ack          host access accepted this cycle
//   host_rdata/rvalid host read data, valid for one cycle
//   host_halt         host asks for the CPU to be frozen
//   halted            CPU frozen; host owns memory exclusively
//   mem_en/we/addr/wdata     memory control pins (zero when idle)
//   mem_rdata         memory read data, one cycle after a read

module dmem_arbiter #(
  parameter int ADDR_W        = 14,
  parameter int DATA_W        = 32,
  parameter int HOST_WAIT_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  input  logic              host_halt,
  output logic              halted,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_HOST
  } owner_t;

  localparam logic [7:0] WAIT_MAX = 8'(HOST_WAIT_MAX);

  state_t     state;
  state_t     state_next;
  owner_t     rd_owner;
  owner_t     rd_owner_next;
  logic [7:0] wait_cnt;
  logic [7:0] wait_next;
  logic       cpu_gnt;
  logic       host_gnt;

  // Grant decision. Outside RUN the CPU is locked out entirely, so the
  // host simply wins whenever it asks.
  always_comb begin
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    case (state)
      ST_RUN: begin
        if (cpu_req && !(host_req && (wait_cnt == WAIT_MAX))) begin
          cpu_gnt = 1'b1;
        end else if (host_req) begin
          host_gnt = 1'b1;
        end
      end
      default: begin
        host_gnt = host_req;
      end
    endcase
  end

  // Memory pins follow the winner and are forced to zero when idle, so
  // the two requesters can never be merged into one access.
  always_comb begin
    mem_en    = cpu_gnt | host_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (host_gnt) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign host_ack  = host_gnt;

  // Starvation counter: counts consecutive denied host cycles and
  // saturates at the limit. It is held at zero outside RUN because the
  // host can't be denied there.
  always_comb begin
    wait_next = '0;
    if ((state == ST_RUN) && host_req && !host_gnt) begin
      if (wait_cnt < WAIT_MAX) begin
        wait_next = wait_cnt + 8'd1;
      end else begin
        wait_next = wait_cnt;
      end
    end
  end

  // Halt sequencing. DRAIN lasts exactly one cycle so a CPU read issued
  // in the last RUN cycle still returns its data before halted rises.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:    state_next = host_halt ? ST_DRAIN : ST_RUN;
      ST_DRAIN:  state_next = ST_HALTED;
      ST_HALTED: state_next = host_halt ? ST_HALTED : ST_RUN;
      default:   state_next = ST_RUN;
    endcase
  end

  // Remember who issued this cycle's read so the returning data can be
  // steered to the right requester on the next cycle.
  always_comb begin
    rd_owner_next = OWN_NONE;
    if (mem_en && !mem_we) begin
      rd_owner_next = cpu_gnt ? OWN_CPU : OWN_HOST;
    end
  end

  // Reset deliberately discards any read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      rd_owner <= OWN_NONE;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      rd_owner <= rd_owner_next;
    end
  end

  assign cpu_rvalid  = (rd_owner == OWN_CPU);
  assign host_rvalid = (rd_owner == OWN_HOST);
  assign cpu_rdata   = mem_rdata;
  assign host_rdata  = mem_rdata;
  assign halted      = (state == ST_HALTED);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter. A behavioural synchronous memory
//   answers the main instance. A second instance with HOST_WAIT_MAX=1
//   shares the same inputs so that the alternating-grant case can be
//   seen alongside the default configuration.

module tb_dmem_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_halt;
  logic [DW-1:0] mem_rdata;

  logic          cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic          host_rvalid;
  logic          halted;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  logic          s_cpu_stall;
  logic [DW-1:0] s_cpu_rdata;
  logic          s_cpu_rvalid;
  logic          s_host_ack;
  logic [DW-1:0] s_host_rdata;
  logic          s_host_rvalid;
  logic          s_halted;
  logic          s_mem_en;
  logic          s_mem_we;
  logic [AW-1:0] s_mem_addr;
  logic [DW-1:0] s_mem_wdata;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HOST_WAIT_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .host_halt(host_halt), .halted(halted),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HOST_WAIT_MAX(1)) dut1 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(s_cpu_stall), .cpu_rdata(s_cpu_rdata), .cpu_rvalid(s_cpu_rvalid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(s_host_ack), .host_rdata(s_host_rdata), .host_rvalid(s_host_rvalid),
    .host_halt(host_halt), .halted(s_halted),
    .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port synchronous memory driven by the main instance.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  // Inputs change on the falling edge; outputs are sampled 1 time unit later,
  // well away from the rising edge.
  task automatic applyStimulus(input logic r,
                               input logic cr, input logic cw,
                               input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                               input logic hr, input logic hw,
                               input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                               input logic hh);
    @(negedge clk);
    rst        = r;
    cpu_req    = cr;
    cpu_we     = cw;
    cpu_addr   = ca;
    cpu_wdata  = cd;
    host_req   = hr;
    host_we    = hw;
    host_addr  = ha;
    host_wdata = hd;
    host_halt  = hh;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    host_halt = 1'b0; mem_rdata = '0;
    mem[14'h0010] = 32'hDEADBEEF;
    mem[14'h0020] = 32'h20202020;
    mem[14'h0030] = 32'h30303030;

    $display("[TB] reset state");
    applyStimulus(1, 0, 0, 14'h0, 32'h0, 0, 0, 14'h0, 32'h0, 0);
    checkOutput("rst_cpu_rvalid", cpu_rvalid, 0);
    checkOutput("rst_host_rvalid", host_rvalid, 0);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_mem_en", mem_en, 0);

    $display("[TB] single CPU read");
    applyStimulus(0, 1, 0, 14'h0010, 32'h0, 0, 0, 14'h0, 32'h0, 0);
    checkOutput("rd_mem_en", mem_en, 1);
    checkOutput("rd_mem_we", mem_we, 0);
    checkOutput("rd_mem_addr", mem_addr, 32'h0010);
    checkOutput("rd_cpu_stall", cpu_stall, 0);
    checkOutput("rd_host_ack", host_ack, 0);
    checkOutput("rd_cpu_rvalid_early", cpu_rvalid, 0);
    applyStimulus(0, 0, 0, 14'h0, 32'h0, 0, 0, 14'h0, 32'h0, 0);
    checkOutput("rd_cpu_rvalid", cpu_rvalid, 1);
    checkOutput("rd_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    checkOutput("rd_host_rvalid", host_rvalid, 0);
    checkOutput("idle_mem_en", mem_en, 0);

    $display("[TB] CPU store against host read");
    applyStimulus(0, 1, 1, 14'h0004, 32'h12345678, 1, 0, 14'h0008, 32'h0, 0);
    checkOutput("st_mem_en", mem_en, 1);
    checkOutput("st_mem_we", mem_we, 1);
    checkOutput("st_mem_addr", mem_addr, 32'h0004);
    checkOutput("st_mem_wdata", mem_wdata, 32'h12345678);
    checkOutput("st_host_ack", host_ack, 0);
    checkOutput("st_cpu_stall", cpu_stall, 0);
    checkOutput("st1_host_ack", s_host_ack, 0);
    applyStimulus(0, 1, 1, 14'h0004, 32'h12345678, 1, 0, 14'h0008, 32'h0, 0);
    checkOutput("st2_host_ack", host_ack, 0);
    checkOutput("st2_w1_host_ack", s_host_ack, 1);
    checkOutput("st2_w1_cpu_stall", s_cpu_stall, 1);
    checkOutput("st2_w1_mem_addr", s_mem_addr, 32'h0008);
    checkOutput("st2_w1_mem_we", s_mem_we, 0);
    applyStimulus(0, 0, 0, 14'h0, 32'h0, 0, 0, 14'h0, 32'h0, 0);
    checkOutput("idle_mem_we", mem_we, 0);
    checkOutput("idle_mem_addr", mem_addr, 0);
    checkOutput("idle_mem_wdata", mem_wdata, 0);
    checkOutput("st_cpu_rvalid", cpu_rvalid, 0);
    checkOutput("st_w1_host_rvalid", s_host_rvalid, 1);

    $display("[TB] sustained contention");
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(0, 1, 0, 14'h0020, 32'h0, 1, 0, 14'h0030, 32'h0, 0);
      checkOutput($sformatf("cont%0d_host_ack", k), host_ack, (k == 9) ? 1 : 0);
      checkOutput($sformatf("cont%0d_cpu_stall", k), cpu_stall, (k == 9) ? 1 : 0);
      checkOutput($sformatf("cont%0d_mem_addr", k), mem_addr, (k == 9) ? 32'h0030 : 32'h0020);
      checkOutput($sformatf("cont%0d_cpu_rvalid", k), cpu_rvalid, ((k > 1) && (k != 10)) ? 1 : 0);
      checkOutput($sformatf("cont%0d_host_rvalid", k), host_rvalid, (k == 10) ? 1 : 0);
      if (k == 10) begin
        checkOutput("cont10_host_rdata", host_rdata, 32'h30303030);
      end else if (k > 1) begin
        checkOutput($sformatf("cont%0d_cpu_rdata", k), cpu_rdata, 32'h20202020);
      end
      checkOutput($sformatf("cont%0d_w1_host_ack", k), s_host_ack, (k % 2 == 0) ? 1 : 0);
      checkOutput($sformatf("cont%0d_w1_cpu_stall", k), s_cpu_stall, (k % 2 == 0) ? 1 : 0);
      checkOutput($sformatf("cont%0d_w1_host_rvalid", k), s_host_rvalid,
                  ((k > 1) && ((k - 1) % 2 == 0)) ? 1 : 0);
      checkOutput($sformatf("cont%0d_w1_cpu_rvalid", k), s_cpu_rvalid,
                  ((k > 1) && ((k - 1) % 2 == 1)) ? 1 : 0);
    end
    applyStimulus(0, 0, 0, 14'h0, 32'h0, 0, 0, 14'h0, 32'h0, 0);
    checkOutput("cont_tail_cpu_rvalid", cpu_rvalid, 1);
    checkOutput("cont_tail_cpu_rdata", cpu_rdata, 32'h20202020);

    $display("[TB] halt entry");
    applyStimulus(0, 1, 0, 14'h0010, 32'h0, 0, 0, 14'h0, 32'h0, 1);
    checkOutput("h0_mem_en", mem_en, 1);
    checkOutput("h0_cpu_stall", cpu_stall, 0);
    checkOutput("h0_halted", halted, 0);
    applyStimulus(0, 1, 0, 14'h0020, 32'h0, 0, 0, 14'h0, 32'h0, 1);
    checkOutput("drain_cpu_rvalid", cpu_rvalid, 1);
    checkOutput("drain_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    checkOutput("drain_cpu_stall", cpu_stall, 1);
    checkOutput("drain_mem_en", mem_en, 0);
    checkOutput("drain_halted", halted, 0);
    applyStimulus(0, 1, 0, 14'h0020, 32'h0, 1, 1, 14'h3FFF, 32'hA5A5A5A5, 1);
    checkOutput("hw_halted", halted, 1);
    checkOutput("hw_cpu_stall", cpu_stall, 1);
    checkOutput("hw_host_ack", host_ack, 1);
    checkOutput("hw_mem_we", mem_we, 1);
    checkOutput("hw_mem_addr", mem_addr, 32'h3FFF);
    checkOutput("hw_mem_wdata", mem_wdata, 32'hA5A5A5A5);
    checkOutput("hw_cpu_rvalid", cpu_rvalid, 0);
    applyStimulus(0, 1, 0, 14'h0020, 32'h0, 1, 0, 14'h3FFF, 32'h0, 1);
    checkOutput("hr_host_ack", host_ack, 1);
    checkOutput("hr_cpu_stall", cpu_stall, 1);
    checkOutput("hr_mem_we", mem_we, 0);
    checkOutput("hr_mem_addr", mem_addr, 32'h3FFF);
    checkOutput("hr_halted", halted, 1);

    $display("[TB] halt exit");
    applyStimulus(0, 0, 0, 14'h0, 32'h0, 0, 0, 14'h0, 32'h0, 0);
    checkOutput("hx_host_rvalid", host_rvalid, 1);
    checkOutput("hx_host_rdata", host_rdata, 32'hA5A5A5A5);
    checkOutput("hx_cpu_rvalid", cpu_rvalid, 0);
    checkOutput("hx_halted", halted, 1);
    applyStimulus(0, 1, 0, 14'h0030, 32'h0, 0, 0, 14'h0, 32'h0, 0);
    checkOutput("run_halted", halted, 0);
    checkOutput("run_cpu_stall", cpu_stall, 0);
    checkOutput("run_mem_en", mem_en, 1);
    checkOutput("run_mem_addr", mem_addr, 32'h0030);

    $display("[TB] reset during a host read");
    applyStimulus(1, 0, 0, 14'h0, 32'h0, 1, 0, 14'h3FFF, 32'h0, 1);
    checkOutput("rr_cpu_rvalid", cpu_rvalid, 1);
    checkOutput("rr_cpu_rdata", cpu_rdata, 32'h30303030);
    checkOutput("rr_host_ack", host_ack, 1);
    applyStimulus(0, 1, 0, 14'h0010, 32'h0, 0, 0, 14'h0, 32'h0, 1);
    checkOutput("rr_host_rvalid", host_rvalid, 0);
    checkOutput("rr_halted", halted, 0);
    checkOutput("rr_cpu_stall", cpu_stall, 0);
    checkOutput("rr_mem_en", mem_en, 1);
    applyStimulus(0, 1, 0, 14'h0010, 32'h0, 0, 0, 14'h0, 32'h0, 1);
    checkOutput("rr_drain_cpu_stall", cpu_stall, 1);
    checkOutput("rr_drain_mem_en", mem_en, 0);
    checkOutput("rr_drain_cpu_rvalid", cpu_rvalid, 1);
    applyStimulus(0, 0, 0, 14'h0, 32'h0, 0, 0, 14'h0, 32'h0, 1);
    checkOutput("rr_halted_on", halted, 1);
    applyStimulus(0, 0, 0, 14'h0, 32'h0, 0, 0, 14'h0, 32'h0, 0);
    checkOutput("rr_halted_hold", halted, 1);
    applyStimulus(0, 0, 0, 14'h0, 32'h0, 0, 0, 14'h0, 32'h0, 0);
    checkOutput("rr_halted_off", halted, 0);
    checkOutput("rr_final_mem_en", mem_en, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
